// File: rtl/menu_pkg.sv
// Shared definitions for the menu selection controller and its byte mux.
package menu_pkg;

    typedef enum logic {
        BROWSE = 1'b0,
        LOCKED = 1'b1
    } menu_state_e;

    localparam int unsigned SEL_W         = 4;
    localparam int unsigned ITEM_W        = 8;
    localparam int unsigned NUM_ITEMS_DEF = 11;

    // Button bit positions inside the edge-detector vector
    localparam int unsigned NUM_BTNS = 4;
    localparam int unsigned B_NEXT   = 0;
    localparam int unsigned B_PREV   = 1;
    localparam int unsigned B_OK     = 2;
    localparam int unsigned B_CANCEL = 3;

    // Index one step forward, wrapping from n-1 back to 0
    function automatic logic [SEL_W-1:0] sel_wrap_inc(input logic [SEL_W-1:0] s,
                                                      input int unsigned      n);
        return (32'(s) == n - 1) ? '0 : s + 1'b1;
    endfunction

    // Index one step back, wrapping from 0 to n-1
    function automatic logic [SEL_W-1:0] sel_wrap_dec(input logic [SEL_W-1:0] s,
                                                      input int unsigned      n);
        return (s == '0) ? SEL_W'(n - 1) : s - 1'b1;
    endfunction

endpackage

// File: rtl/t_menu_sel_ctrl_btn_edge.sv
// Rising-edge detector for a vector of debounced button levels.
// The previous-sample register resets to all ones, so a button held
// through reset does not register as a press.
module btn_edge #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;

    // Remember last cycle's button levels
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '1;
        end else begin
            prev_q <= btn_i;
        end
    end

    // A press is high now but low on the previous sample
    always_comb begin
        rise_o = btn_i & ~prev_q;
    end

endmodule

// File: rtl/t_menu_sel_ctrl.sv
// Menu selection controller feeding the select of an N:1 byte mux.
// Buttons browse the index with wrap-around, ok captures the mux byte and
// locks, cancel unlocks (or homes the index while browsing).
// Optional feature macro: MENU_AUTOSCAN_EN enables an idle auto-scan counter.
module t_menu_sel_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = NUM_ITEMS_DEF,
    parameter int unsigned SCAN_TICKS = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_ok,
    input  logic              btn_cancel,
    input  logic [ITEM_W-1:0] mux_y,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_changed,
    output logic [ITEM_W-1:0] item_code,
    output logic              item_valid,
    output logic              locked
);

    if (NUM_ITEMS < 2 || NUM_ITEMS > 16 || SCAN_TICKS < 1) begin : g_bad_params
        $error("t_menu_sel_ctrl: NUM_ITEMS must be 2..16 and SCAN_TICKS >= 1");
    end

    menu_state_e       state_q;
    logic [SEL_W-1:0]  sel_q;
    logic              sel_changed_q;
    logic [ITEM_W-1:0] item_code_q;
    logic              item_valid_q;

    logic [NUM_BTNS-1:0] btn_lvl;
    logic [NUM_BTNS-1:0] rise;
    logic                any_edge;
    logic                step_fwd;
    logic                step_back;

    assign btn_lvl[B_NEXT]   = btn_next;
    assign btn_lvl[B_PREV]   = btn_prev;
    assign btn_lvl[B_OK]     = btn_ok;
    assign btn_lvl[B_CANCEL] = btn_cancel;

    btn_edge #(
        .W (NUM_BTNS)
    ) u_btn_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_lvl),
        .rise_o (rise)
    );

    assign any_edge = |rise;

`ifdef MENU_AUTOSCAN_EN
    localparam int unsigned CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

    logic [CNT_W-1:0] scan_q;
    logic             scan_hit;

    // Idle BROWSE cycle on which the counter reaches its last tick
    assign scan_hit = (state_q == BROWSE) && !any_edge &&
                      (scan_q == CNT_W'(SCAN_TICKS - 1));

    // Idle counter: cleared by any press, by wrapping, and while locked
    always_ff @(posedge clk) begin
        if (reset || state_q == LOCKED || any_edge || scan_hit) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Forward step from a lone next press or an auto-scan wrap
    always_comb begin
        step_fwd  = (rise[B_NEXT] & ~rise[B_PREV]) | scan_hit;
        step_back = rise[B_PREV] & ~rise[B_NEXT];
    end
`else
    // Forward/back steps from lone next/prev presses; simultaneous ones cancel
    always_comb begin
        step_fwd  = rise[B_NEXT] & ~rise[B_PREV];
        step_back = rise[B_PREV] & ~rise[B_NEXT];
    end
`endif

    // Browse/lock FSM with index, capture register and output pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BROWSE;
            sel_q         <= '0;
            sel_changed_q <= 1'b0;
            item_code_q   <= '0;
            item_valid_q  <= 1'b0;
        end else begin
            sel_changed_q <= 1'b0;
            item_valid_q  <= 1'b0;
            unique case (state_q)
                BROWSE: begin
                    if (rise[B_OK]) begin
                        item_code_q  <= mux_y;
                        item_valid_q <= 1'b1;
                        state_q      <= LOCKED;
                    end else if (rise[B_CANCEL]) begin
                        sel_q         <= '0;
                        sel_changed_q <= (sel_q != '0);
                    end else if (step_fwd) begin
                        sel_q         <= sel_wrap_inc(sel_q, NUM_ITEMS);
                        sel_changed_q <= 1'b1;
                    end else if (step_back) begin
                        sel_q         <= sel_wrap_dec(sel_q, NUM_ITEMS);
                        sel_changed_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (rise[B_CANCEL]) begin
                        state_q <= BROWSE;
                    end
                end
                default: state_q <= BROWSE;
            endcase
        end
    end

    assign sel         = sel_q;
    assign sel_changed = sel_changed_q;
    assign item_code   = item_code_q;
    assign item_valid  = item_valid_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_t_menu_sel_ctrl.sv
// Scoreboard bench for t_menu_sel_ctrl: a behavioural model pushes the
// expected pulse events, a monitor pops and compares them against the DUT.
module tb_t_menu_sel_ctrl;

    localparam int unsigned N    = 11;
    localparam int unsigned SCAN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next, btn_prev, btn_ok, btn_cancel;
    logic [7:0] mux_y;
    logic [3:0] sel;
    logic       sel_changed;
    logic [7:0] item_code;
    logic       item_valid;
    logic       locked;

    logic [7:0] tbl [16];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nchg     = 0;

    typedef struct {
        int       cyc;
        bit       chg;
        bit       iv;
        logic [7:0] code;
    } ev_t;
    ev_t q[$];

    // Behavioural model state
    int         m_idx  = 0;
    bit         m_lk   = 0;
    logic [7:0] m_code = 8'h00;
    bit [3:0]   m_prev = 4'hF;
    int         m_cnt  = 0;

    always #5 clk = ~clk;

    // Environment mux: byte table indexed by the DUT's select
    assign mux_y = (sel < 4'(N)) ? tbl[sel] : 8'hEE;

    t_menu_sel_ctrl #(
        .NUM_ITEMS  (N),
        .SCAN_TICKS (SCAN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .btn_ok      (btn_ok),
        .btn_cancel  (btn_cancel),
        .mux_y       (mux_y),
        .sel         (sel),
        .sel_changed (sel_changed),
        .item_code   (item_code),
        .item_valid  (item_valid),
        .locked      (locked)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the menu rules on each rising clock edge
    always @(posedge clk) begin
        bit [3:0] now, r;
        bit       chg, iv;
        cyc++;
        now = {btn_cancel, btn_ok, btn_prev, btn_next};
        if (reset) begin
            m_idx = 0; m_lk = 0; m_code = 8'h00; m_prev = 4'hF; m_cnt = 0;
        end else begin
            r = now & ~m_prev;
            m_prev = now;
            chg = 0; iv = 0;
            if (!m_lk) begin
                if (r[2]) begin
                    m_code = tbl[m_idx]; iv = 1; m_lk = 1; m_cnt = 0;
                end else if (r[3]) begin
                    chg = (m_idx != 0); m_idx = 0; m_cnt = 0;
                end else if (r[0] && !r[1]) begin
                    m_idx = (m_idx + 1) % N; chg = 1; m_cnt = 0;
                end else if (r[1] && !r[0]) begin
                    m_idx = (m_idx + N - 1) % N; chg = 1; m_cnt = 0;
                end else if (r != 0) begin
                    m_cnt = 0;
                end else begin
`ifdef MENU_AUTOSCAN_EN
                    m_cnt++;
                    if (m_cnt == SCAN) begin
                        m_cnt = 0; m_idx = (m_idx + 1) % N; chg = 1;
                    end
`endif
                end
            end else begin
                m_cnt = 0;
                if (r[3]) m_lk = 0;
            end
            if (chg || iv) q.push_back('{cyc: cyc, chg: chg, iv: iv, code: m_code});
        end
    end

    // Monitor: level outputs every cycle, pulse events against the queue
    always @(negedge clk) begin
        ev_t e;
        chk("sel", 32'(sel), 32'(m_idx));
        chk("locked", 32'(locked), 32'(m_lk));
        chk("item_code", 32'(item_code), 32'(m_code));
        if (sel_changed) nchg++;
        if (sel_changed || item_valid) begin
            if (q.size() == 0) begin
                chk("spurious_pulse", {30'd0, sel_changed, item_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("sel_changed", 32'(sel_changed), 32'(e.chg));
                chk("item_valid", 32'(item_valid), 32'(e.iv));
                if (e.iv) chk("captured_code", 32'(item_code), 32'(e.code));
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("missing_pulse", {30'd0, sel_changed, item_valid}, {30'd0, e.chg, e.iv});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle press of the buttons in mask {cancel, ok, prev, next}, then release
    task automatic press(input logic [3:0] m);
        {btn_cancel, btn_ok, btn_prev, btn_next} = m;
        tick();
        {btn_cancel, btn_ok, btn_prev, btn_next} = 4'b0000;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        for (int i = 0; i < 16; i++) tbl[i] = 8'($urandom);
        tbl[3] = 8'hA5;
        reset = 1'b1;
        {btn_cancel, btn_ok, btn_prev, btn_next} = 4'b0000;
        tick(); tick();
        reset = 1'b0;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_item_code", 32'(item_code), 32'h00);
        chk("rst_pulses", {30'd0, sel_changed, item_valid}, 32'd0);
        tick();

`ifndef MENU_AUTOSCAN_EN
        n0 = nchg;
        repeat (11) press(4'b0001);
        chk("wrap_fwd_sel", 32'(sel), 32'd0);
        chk("wrap_fwd_pulses", 32'(nchg - n0), 32'd11);
        chk("wrap_fwd_locked", 32'(locked), 32'd0);

        press(4'b0010);
        chk("wrap_back_sel", 32'(sel), 32'd10);
        n0 = nchg;
        press(4'b0011);
        chk("both_sel", 32'(sel), 32'd10);
        chk("both_pulses", 32'(nchg - n0), 32'd0);

        repeat (4) press(4'b0001);
        chk("pre_ok_sel", 32'(sel), 32'd3);
        btn_ok = 1'b1;
        tick();
        btn_ok = 1'b0;
        chk("ok_item_valid", 32'(item_valid), 32'd1);
        chk("ok_item_code", 32'(item_code), 32'hA5);
        chk("ok_locked", 32'(locked), 32'd1);
        tick();
        chk("ok_valid_one_cycle", 32'(item_valid), 32'd0);
        press(4'b0001); press(4'b0010); press(4'b0100);
        chk("lk_sel", 32'(sel), 32'd3);
        chk("lk_code", 32'(item_code), 32'hA5);
        press(4'b1000);
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_sel", 32'(sel), 32'd3);

        btn_next = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("held_sel", 32'(sel), 32'd0);
        btn_next = 1'b0;
        tick();
        press(4'b0001);
        chk("held_release_sel", 32'(sel), 32'd1);

        btn_ok = 1'b1;
        tick();
        btn_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ok_rst_code", 32'(item_code), 32'h00);
        chk("ok_rst_locked", 32'(locked), 32'd0);
        chk("ok_rst_sel", 32'(sel), 32'd0);
        tick();
        chk("ok_rst_no_valid", 32'(item_valid), 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) < 2);
            btn_next   = ($urandom_range(0, 2) == 0);
            btn_prev   = ($urandom_range(0, 3) == 0);
            btn_ok     = ($urandom_range(0, 9) == 0);
            btn_cancel = ($urandom_range(0, 7) == 0);
            tick();
        end
        reset = 1'b0;
        {btn_cancel, btn_ok, btn_prev, btn_next} = 4'b0000;
        repeat (12) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t_menu_sel_ctrl.md
# t_menu_sel_ctrl

- Menu selection controller directly upstream of the 11:1 byte mux.
- Turns button presses into the 4-bit `sel` index that drives the mux, with wrap-around browsing.
- Captures the mux's selected byte on confirm and holds it, locked, for downstream recipe logic.
- Optional auto-scan cycles the index when the user is idle.

## Interface
Parameters:
- `NUM_ITEMS`, 11: number of valid `sel` codes, 0..NUM_ITEMS-1; legal range 2..16.
- `SCAN_TICKS`, 100_000_000: idle cycles per auto-scan step (1 s at 100 MHz); used only with auto-scan.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_next`  in  1  debounced level; rising edge advances the index.
- `btn_prev`  in  1  debounced level; rising edge decrements the index.
- `btn_ok`  in  1  debounced level; rising edge confirms the current item.
- `btn_cancel`  in  1  debounced level; rising edge unlocks, or homes the index.
- `mux_y`  in  8  combinational mux output for the current `sel`.
- `sel`  out  4  registered mux select index.
- `sel_changed`  out  1  one-cycle pulse after any `sel` update.
- `item_code`  out  8  captured `mux_y` value, held until the next confirm.
- `item_valid`  out  1  one-cycle pulse when `item_code` is updated.
- `locked`  out  1  high while in LOCKED.

## Operation
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- Edge detect per button:
  - Previous-sample registers; edge = `btn & ~btn_d`.
  - `btn_d` resets to 1, so a button held through reset produces no edge.
- FSM states:
  - BROWSE (reset state).
  - LOCKED.
- BROWSE behaviour:
  - next edge: `sel` = (`sel`==NUM_ITEMS-1) ? 0 : `sel`+1.
  - prev edge: `sel` = (`sel`==0) ? NUM_ITEMS-1 : `sel`-1.
  - next and prev edges in the same cycle: both ignored, `sel` unchanged.
  - ok edge: `item_code` <= `mux_y`, `item_valid` pulses, go to LOCKED.
  - ok has priority over next/prev/cancel arriving in the same cycle.
  - cancel edge (without ok): `sel` <= 0; `sel_changed` pulses only if `sel` was nonzero.
- LOCKED behaviour:
  - next, prev and ok are ignored.
  - cancel edge: go to BROWSE; `sel` and `item_code` are unchanged.
- `sel_changed` pulses only when the `sel` value actually differs.
- `sel` never leaves 0..NUM_ITEMS-1. Codes ≥ NUM_ITEMS are unreachable, so the mux default is never exercised.
- Reset values:
  - `sel`=0, `sel_changed`=0, `item_code`=8'h00, `item_valid`=0, `locked`=0.
  - FSM=BROWSE, scan counter=0.
- Reset mid-operation (any state): all of the above reset values in the following cycle. Any pending edge is discarded.

## Timing
- Button first sampled high at edge N: the new `sel` is visible after edge N, and `sel_changed` is high for cycle N+1.
- Confirm:
  - `item_code` captures `mux_y` as sampled at edge N, i.e. the byte for the `sel` held before edge N.
  - `item_valid` and `locked` go high after edge N; `item_valid` stays high exactly one cycle.
- Latency from button edge to output: 1 cycle.
- No combinational path from inputs to outputs; all outputs are registered.
- Held button: acts once. The next action requires release (low for ≥1 cycle) and a new rise.

## Configuration
- `MENU_AUTOSCAN_EN` defined:
  - The scan counter increments each cycle in BROWSE.
  - At SCAN_TICKS-1 it wraps to 0 and performs a next-step, with the same wrap and `sel_changed` rules as a button.
  - Any button edge clears the counter to 0.
  - The counter is held at 0 in LOCKED.
  - Counter width is $clog2(SCAN_TICKS).
- `MENU_AUTOSCAN_EN` undefined:
  - No counter is instantiated; `sel` changes only on button edges.
  - `SCAN_TICKS` is unused.

## Structure
- Shared package `menu_pkg`:
  - State encoding: BROWSE=1'b0, LOCKED=1'b1.
  - `SEL_W`=4 and `ITEM_W`=8 constants.
  - Default `NUM_ITEMS`=11, shared with the mux instance.
- Sub-module `btn_edge`:
  - Parameterised width (4 here), reset value 1.
  - Outputs a rise pulse vector.
- The top level holds the FSM, the index register, the capture register and the optional scan counter.

## Test plan
- Reset, then 11 next pulses: `sel` goes 1,2,...,10,0; `sel_changed` pulses 11 times; `locked`=0.
- From `sel`=0, prev pulse: `sel`=10. Then next and prev rising in the same cycle: `sel` stays 10, no `sel_changed`.
- `sel`=3 with `mux_y`=8'hA5, ok pulse: `item_code`=8'hA5 and `item_valid` 1 cycle after the edge, `locked`=1. Then next/prev/ok pulses leave `sel`=3 and `item_code`=8'hA5. Then cancel: `locked`=0, `sel`=3.
- `btn_next` held high through reset and 5 cycles after it: `sel` stays 0. Release, then press: `sel`=1.
- With `MENU_AUTOSCAN_EN` and SCAN_TICKS=4, idle in BROWSE: `sel` advances every 4 cycles and wraps from 10 to 0. A next press mid-count restarts the 4-cycle count. In LOCKED, `sel` is frozen.
- Reset asserted the cycle after an ok edge: `item_code`=0, `locked`=0, `sel`=0 next cycle, no `item_valid` afterwards.
